// File: rtl/wb_reg_timeout.sv
// ---------------------------------------------------------------------------
// wb_reg_timeout
// Registered Wishbone (classic cycle) master-to-slave pipeline slice with
// bus-health logic: slave RTY is absorbed and the transfer re-issued up to
// RETRY_LIMIT times, and a transfer the slave never answers is terminated
// towards the master with ERR after TIMEOUT_CYCLES.
//
// Ports
//   clk, rst_n            clock (posedge) and synchronous active-low reset
//   wbm_*                 master-facing side (from arbiter/mux)
//   wbs_*                 slave-facing side (to slave or bridge)
//   stat_timeout          1-cycle pulse when a transfer times out
//   stat_retry            1-cycle pulse per absorbed slave RTY
// All outputs are registered.
// ---------------------------------------------------------------------------
module wb_reg_timeout #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int RETRY_LIMIT    = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   wbm_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm_dat_o,
    input  logic                    wbm_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm_sel_i,
    input  logic                    wbm_stb_i,
    output logic                    wbm_ack_o,
    output logic                    wbm_err_o,
    output logic                    wbm_rty_o,
    input  logic                    wbm_cyc_i,
    output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
    input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
    output logic [DATA_WIDTH-1:0]   wbs_dat_o,
    output logic                    wbs_we_o,
    output logic [SELECT_WIDTH-1:0] wbs_sel_o,
    output logic                    wbs_stb_o,
    input  logic                    wbs_ack_i,
    input  logic                    wbs_err_i,
    input  logic                    wbs_rty_i,
    output logic                    wbs_cyc_o,
    output logic                    stat_timeout,
    output logic                    stat_retry
);

    // Counter widths; a disabled feature still gets a 1-bit counter so no
    // zero-width vectors appear.
    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int RW = ($clog2(RETRY_LIMIT + 1) > 0) ? $clog2(RETRY_LIMIT + 1) : 1;

    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMR_MAX  = {TW{1'b1}};
    localparam logic [RW-1:0] RTY_MAX  = RW'(RETRY_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [TW-1:0]   timer_r, timer_nxt_s;
    logic [RW-1:0]   retry_r, retry_nxt_s;
    logic            we_r, we_nxt_s;   // latched write enable, re-issued after a GAP

    logic [ADDR_WIDTH-1:0]   adr_nxt_s;
    logic [DATA_WIDTH-1:0]   sdat_nxt_s, mdat_nxt_s;
    logic [SELECT_WIDTH-1:0] sel_nxt_s;
    logic                    swe_nxt_s, stb_nxt_s, cyc_nxt_s;
    logic                    ack_nxt_s, err_nxt_s, rty_nxt_s;
    logic                    stmo_nxt_s, srty_nxt_s;

    logic req_s, tmo_hit_s, can_retry_s;

    assign req_s       = wbm_cyc_i & wbm_stb_i;
    assign tmo_hit_s   = (TIMEOUT_CYCLES != 0) && (timer_r == TMO_LAST);
    assign can_retry_s = (retry_r < RTY_MAX);

    // State and output registers; reset clears everything, including any
    // transfer in flight, so no response for it can ever reach the master.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            timer_r      <= '0;
            retry_r      <= '0;
            we_r         <= 1'b0;
            wbs_adr_o    <= '0;
            wbs_dat_o    <= '0;
            wbs_sel_o    <= '0;
            wbs_we_o     <= 1'b0;
            wbs_stb_o    <= 1'b0;
            wbs_cyc_o    <= 1'b0;
            wbm_dat_o    <= '0;
            wbm_ack_o    <= 1'b0;
            wbm_err_o    <= 1'b0;
            wbm_rty_o    <= 1'b0;
            stat_timeout <= 1'b0;
            stat_retry   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            timer_r      <= timer_nxt_s;
            retry_r      <= retry_nxt_s;
            we_r         <= we_nxt_s;
            wbs_adr_o    <= adr_nxt_s;
            wbs_dat_o    <= sdat_nxt_s;
            wbs_sel_o    <= sel_nxt_s;
            wbs_we_o     <= swe_nxt_s;
            wbs_stb_o    <= stb_nxt_s;
            wbs_cyc_o    <= cyc_nxt_s;
            wbm_dat_o    <= mdat_nxt_s;
            wbm_ack_o    <= ack_nxt_s;
            wbm_err_o    <= err_nxt_s;
            wbm_rty_o    <= rty_nxt_s;
            stat_timeout <= stmo_nxt_s;
            stat_retry   <= srty_nxt_s;
        end
    end

    // Next-state decode; master abort outranks every slave response,
    // and any slave response outranks the timeout.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_s) state_nxt_s = BUSY;
                else       state_nxt_s = IDLE;
            end
            BUSY: begin
                if (!wbm_cyc_i)                  state_nxt_s = IDLE;
                else if (wbs_ack_i || wbs_err_i) state_nxt_s = RESP;
                else if (wbs_rty_i)              state_nxt_s = can_retry_s ? GAP : RESP;
                else if (tmo_hit_s)              state_nxt_s = RESP;
                else                             state_nxt_s = BUSY;
            end
            GAP: begin
                if (!wbm_cyc_i) state_nxt_s = IDLE;
                else            state_nxt_s = BUSY;
            end
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Next values of the registered outputs and counters.
    always_comb begin
        timer_nxt_s = timer_r;
        retry_nxt_s = retry_r;
        we_nxt_s    = we_r;
        adr_nxt_s   = wbs_adr_o;
        sdat_nxt_s  = wbs_dat_o;
        sel_nxt_s   = wbs_sel_o;
        swe_nxt_s   = wbs_we_o;
        stb_nxt_s   = wbs_stb_o;
        cyc_nxt_s   = wbs_cyc_o;
        mdat_nxt_s  = '0;
        ack_nxt_s   = 1'b0;
        err_nxt_s   = 1'b0;
        rty_nxt_s   = 1'b0;
        stmo_nxt_s  = 1'b0;
        srty_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                adr_nxt_s  = wbm_adr_i;
                sdat_nxt_s = wbm_dat_i;
                sel_nxt_s  = wbm_sel_i;
                cyc_nxt_s  = wbm_cyc_i;
                if (req_s) begin
                    stb_nxt_s   = 1'b1;
                    swe_nxt_s   = wbm_we_i;
                    we_nxt_s    = wbm_we_i;
                    timer_nxt_s = '0;
                    retry_nxt_s = '0;
                end else begin
                    stb_nxt_s = 1'b0;
                    swe_nxt_s = 1'b0;
                end
            end
            BUSY: begin
                // Saturating: the timer never wraps, even with the timeout disabled.
                timer_nxt_s = (timer_r == TMR_MAX) ? timer_r : timer_r + TW'(1);
                if (!wbm_cyc_i) begin
                    cyc_nxt_s = 1'b0;
                    stb_nxt_s = 1'b0;
                    swe_nxt_s = 1'b0;
                end else if (wbs_ack_i || wbs_err_i) begin
                    mdat_nxt_s = wbs_dat_i;
                    ack_nxt_s  = wbs_ack_i;
                    err_nxt_s  = ~wbs_ack_i;
                    stb_nxt_s  = 1'b0;
                    swe_nxt_s  = 1'b0;
                end else if (wbs_rty_i) begin
                    stb_nxt_s = 1'b0;
                    swe_nxt_s = 1'b0;
                    if (can_retry_s) begin
                        retry_nxt_s = retry_r + RW'(1);
                        srty_nxt_s  = 1'b1;
                    end else begin
                        rty_nxt_s = 1'b1;
                    end
                end else if (tmo_hit_s) begin
                    err_nxt_s  = 1'b1;
                    stmo_nxt_s = 1'b1;
                    stb_nxt_s  = 1'b0;
                    swe_nxt_s  = 1'b0;
                end else begin
                    stb_nxt_s = 1'b1;
                end
            end
            GAP: begin
                if (!wbm_cyc_i) begin
                    cyc_nxt_s = 1'b0;
                    stb_nxt_s = 1'b0;
                    swe_nxt_s = 1'b0;
                end else begin
                    stb_nxt_s   = 1'b1;
                    swe_nxt_s   = we_r;
                    timer_nxt_s = '0;
                end
            end
            RESP: begin
                stb_nxt_s = 1'b0;
                swe_nxt_s = 1'b0;
            end
            default: begin
                stb_nxt_s = 1'b0;
                swe_nxt_s = 1'b0;
                cyc_nxt_s = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_reg_timeout.sv
// Directed bench for wb_reg_timeout (TIMEOUT_CYCLES=16, RETRY_LIMIT=2).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_wb_reg_timeout;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] wbm_adr_i, wbm_dat_i, wbm_dat_o;
    logic        wbm_we_i, wbm_stb_i, wbm_ack_o, wbm_err_o, wbm_rty_o, wbm_cyc_i;
    logic [3:0]  wbm_sel_i, wbs_sel_o;
    logic [31:0] wbs_adr_o, wbs_dat_i, wbs_dat_o;
    logic        wbs_we_o, wbs_stb_o, wbs_ack_i, wbs_err_i, wbs_rty_i, wbs_cyc_o;
    logic        stat_timeout, stat_retry;

    int n_cmp = 0;
    int n_bad = 0;

    wb_reg_timeout #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4),
        .TIMEOUT_CYCLES(16), .RETRY_LIMIT(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_dat_o(wbm_dat_o),
        .wbm_we_i(wbm_we_i), .wbm_sel_i(wbm_sel_i), .wbm_stb_i(wbm_stb_i),
        .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
        .wbm_cyc_i(wbm_cyc_i),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_i(wbs_dat_i), .wbs_dat_o(wbs_dat_o),
        .wbs_we_o(wbs_we_o), .wbs_sel_o(wbs_sel_o), .wbs_stb_o(wbs_stb_o),
        .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i),
        .wbs_cyc_o(wbs_cyc_o),
        .stat_timeout(stat_timeout), .stat_retry(stat_retry)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic master_req(input logic [31:0] adr, input logic [31:0] dat, input logic we);
        wbm_adr_i = adr;
        wbm_dat_i = dat;
        wbm_we_i  = we;
        wbm_sel_i = 4'hF;
        wbm_cyc_i = 1'b1;
        wbm_stb_i = 1'b1;
    endtask

    task automatic master_idle();
        wbm_cyc_i = 1'b0;
        wbm_stb_i = 1'b0;
        wbm_we_i  = 1'b0;
        wbs_ack_i = 1'b0;
        wbs_err_i = 1'b0;
        wbs_rty_i = 1'b0;
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        wbm_adr_i = 32'h0;
        wbm_dat_i = 32'h0;
        wbm_sel_i = 4'h0;
        wbs_dat_i = 32'h0;
        master_idle();
        tick();
        tick();
        check_val("rst_stb", {63'd0, wbs_stb_o}, 64'd0);
        check_val("rst_cyc", {63'd0, wbs_cyc_o}, 64'd0);
        check_val("rst_flags", {61'd0, wbm_ack_o, wbm_err_o, wbm_rty_o}, 64'd0);
        rst_n = 1'b1;
        tick();

        // T1: write, slave acks on the first strobe cycle
        master_req(32'h100, 32'hDEADBEEF, 1'b1);
        wbs_ack_i = 1'b1;
        tick();
        check_val("t1_stb", {63'd0, wbs_stb_o}, 64'd1);
        check_val("t1_we", {63'd0, wbs_we_o}, 64'd1);
        check_val("t1_adr", {32'd0, wbs_adr_o}, 64'h100);
        check_val("t1_dat", {32'd0, wbs_dat_o}, 64'hDEADBEEF);
        check_val("t1_sel", {60'd0, wbs_sel_o}, 64'hF);
        check_val("t1_ack_early", {63'd0, wbm_ack_o}, 64'd0);
        tick();
        check_val("t1_ack", {63'd0, wbm_ack_o}, 64'd1);
        check_val("t1_we_low", {63'd0, wbs_we_o}, 64'd0);
        check_val("t1_stb_low", {63'd0, wbs_stb_o}, 64'd0);
        master_idle();
        tick();
        check_val("t1_ack_1cyc", {63'd0, wbm_ack_o}, 64'd0);
        tick();

        // T2: read with three wait states
        master_req(32'h200, 32'h0, 1'b0);
        tick();
        check_val("t2_stb", {63'd0, wbs_stb_o}, 64'd1);
        check_val("t2_we", {63'd0, wbs_we_o}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("t2_wait_ack", {63'd0, wbm_ack_o}, 64'd0);
            check_val("t2_wait_dat", {32'd0, wbm_dat_o}, 64'd0);
        end
        wbs_ack_i = 1'b1;
        wbs_dat_i = 32'h12345678;
        tick();
        check_val("t2_ack", {63'd0, wbm_ack_o}, 64'd1);
        check_val("t2_dat", {32'd0, wbm_dat_o}, 64'h12345678);
        master_idle();
        tick();
        check_val("t2_ack_clr", {63'd0, wbm_ack_o}, 64'd0);
        check_val("t2_dat_clr", {32'd0, wbm_dat_o}, 64'd0);
        tick();

        // T3a: rty, rty, ack -> two absorbed retries, master sees ack only
        master_req(32'h300, 32'hA5A5A5A5, 1'b1);
        tick();
        for (int r = 0; r < 2; r++) begin
            wbs_rty_i = 1'b1;
            tick();
            check_val("t3_gap_stb", {63'd0, wbs_stb_o}, 64'd0);
            check_val("t3_gap_cyc", {63'd0, wbs_cyc_o}, 64'd1);
            check_val("t3_retry_pulse", {63'd0, stat_retry}, 64'd1);
            check_val("t3_no_rty", {63'd0, wbm_rty_o}, 64'd0);
            wbs_rty_i = 1'b0;
            tick();
            check_val("t3_restb", {63'd0, wbs_stb_o}, 64'd1);
            check_val("t3_rewe", {63'd0, wbs_we_o}, 64'd1);
            check_val("t3_readr", {32'd0, wbs_adr_o}, 64'h300);
            check_val("t3_retry_1cyc", {63'd0, stat_retry}, 64'd0);
        end
        wbs_ack_i = 1'b1;
        tick();
        check_val("t3_ack", {61'd0, wbm_ack_o, wbm_err_o, wbm_rty_o}, 64'b100);
        master_idle();
        tick();
        tick();

        // T3b: three RTYs in a row -> RTY reaches the master once
        master_req(32'h304, 32'h0, 1'b0);
        tick();
        wbs_rty_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_val("t3b_no_rty", {63'd0, wbm_rty_o}, 64'd0);
        end
        tick();
        check_val("t3b_rty", {61'd0, wbm_ack_o, wbm_err_o, wbm_rty_o}, 64'b001);
        check_val("t3b_no_pulse", {63'd0, stat_retry}, 64'd0);
        master_idle();
        tick();
        check_val("t3b_rty_clr", {63'd0, wbm_rty_o}, 64'd0);
        tick();

        // T4: silent slave -> ERR 17 cycles after the master strobe
        master_req(32'h400, 32'h0, 1'b0);
        tick();
        check_val("t4_stb", {63'd0, wbs_stb_o}, 64'd1);
        n = 0;
        while (!wbm_err_o && n < 40) begin
            tick();
            n++;
        end
        check_val("t4_latency", 64'(n), 64'd16);
        check_val("t4_stat", {63'd0, stat_timeout}, 64'd1);
        check_val("t4_stb_low", {63'd0, wbs_stb_o}, 64'd0);
        check_val("t4_dat", {32'd0, wbm_dat_o}, 64'd0);
        master_idle();
        tick();
        check_val("t4_err_clr", {62'd0, wbm_err_o, stat_timeout}, 64'd0);
        tick();

        // Response on the expiry cycle wins over the timeout
        master_req(32'h404, 32'h0, 1'b0);
        tick();
        for (int i = 0; i < 15; i++) tick();
        wbs_ack_i = 1'b1;
        wbs_dat_i = 32'h0BADF00D;
        tick();
        check_val("t4b_ack", {61'd0, wbm_ack_o, wbm_err_o, wbm_rty_o}, 64'b100);
        check_val("t4b_no_tmo", {63'd0, stat_timeout}, 64'd0);
        check_val("t4b_dat", {32'd0, wbm_dat_o}, 64'h0BADF00D);
        master_idle();
        tick();
        tick();

        // T5: master abort mid-BUSY, late slave ack ignored
        master_req(32'h500, 32'h0, 1'b0);
        tick();
        tick();
        master_idle();
        tick();
        check_val("t5_cyc", {63'd0, wbs_cyc_o}, 64'd0);
        check_val("t5_stb", {63'd0, wbs_stb_o}, 64'd0);
        check_val("t5_flags", {61'd0, wbm_ack_o, wbm_err_o, wbm_rty_o}, 64'd0);
        wbs_ack_i = 1'b1;
        tick();
        check_val("t5_late_ack", {63'd0, wbm_ack_o}, 64'd0);
        master_idle();
        tick();

        // T6a: ack and err together -> ack only
        master_req(32'h600, 32'h0, 1'b0);
        tick();
        wbs_ack_i = 1'b1;
        wbs_err_i = 1'b1;
        tick();
        check_val("t6_ack_wins", {61'd0, wbm_ack_o, wbm_err_o, wbm_rty_o}, 64'b100);
        master_idle();
        tick();
        tick();

        // T6b: reset while BUSY
        master_req(32'h604, 32'h11112222, 1'b1);
        tick();
        check_val("t6_busy_stb", {63'd0, wbs_stb_o}, 64'd1);
        rst_n = 1'b0;
        wbs_ack_i = 1'b1;
        tick();
        check_val("t6_rst_stb", {62'd0, wbs_stb_o, wbs_cyc_o}, 64'd0);
        check_val("t6_rst_adr", {32'd0, wbs_adr_o}, 64'd0);
        check_val("t6_rst_flags", {61'd0, wbm_ack_o, wbm_err_o, wbm_rty_o}, 64'd0);
        master_idle();
        wbs_ack_i = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("t6_no_resp", {61'd0, wbm_ack_o, wbm_err_o, wbm_rty_o}, 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
